l2todr_pfreq_queue: RTL
=======================

# l2todr_pfreq_queue

Prefetch request buffer between the L2 prefetch port and the directory bank's `l2todr_pfreq` input. It absorbs bursty L2 prefetch traffic in a circular queue of configurable depth and never back-pressures the L2 in normal operation. When the queue is full, the oldest entry is dropped. Prefetch requests have no ack, so drops are silent to the L2 and are counted only for performance monitoring.

## Interface
Parameters:
- `DEPTH`, default 8: queue entries. Legal values are 4, 8 and 16 (power of two).
- `CNTW`, default 16: width of the drop counter.

Ports:
- `clk`  in  1  single clock; everything is posedge.
- `reset`  in  1  synchronous, active-high.
- `l2todr_pfreq_valid`  in  1  L2 request valid.
- `l2todr_pfreq_retry`  out  1  retry to the L2.
- `l2todr_pfreq`  in  `$bits(I_l2todr_pfreq_type)`  request payload; the `paddr` field holds the line address.
- `dr_pfreq_valid`  out  1  request valid toward the directory bank.
- `dr_pfreq_retry`  in  1  retry from the directory bank.
- `dr_pfreq`  out  `$bits(I_l2todr_pfreq_type)`  oldest queued request.
- `pfreq_drop_cnt`  out  `CNTW`  saturating count of overflow drops.

## Operation
Handshake:
- A transfer occurs on a cycle where valid=1 and retry=0.
- Input push = `l2todr_pfreq_valid & !l2todr_pfreq_retry`.
- Output pop = `dr_pfreq_valid & !dr_pfreq_retry`.

Retry and output valid:
- `l2todr_pfreq_retry` = `reset`, combinational. It is 0 at all other times; the block never stalls the L2.
- `dr_pfreq_valid` = (count != 0).
- `dr_pfreq` = storage[head].

State:
- `head` and `tail` pointers, `$clog2(DEPTH)` bits each. They wrap naturally at DEPTH.
- `count`, `$clog2(DEPTH)+1` bits.
- Entry storage array. It is not reset.

Per-cycle rules:
- Push only, not full: write storage[tail], tail+1, count+1.
- Pop only: head+1, count-1.
- Push and pop, any occupancy (including full): write storage[tail], tail+1, head+1, count unchanged. No drop.
- Push, full, no pop (overflow): write storage[tail] (== head slot), tail+1, head+1, count stays DEPTH, `pfreq_drop_cnt`+1.
- Overflow while `dr_pfreq_valid & dr_pfreq_retry`: the presented entry changes to the next-oldest. This is legal because the directory samples only on the accepting cycle.
- Empty, push and pop in the same cycle: impossible, because `dr_pfreq_valid`=0. There is no bypass.

Counter:
- `pfreq_drop_cnt` saturates at all-ones and does not wrap.

## Timing
- Latency: a push accepted in cycle N appears on `dr_pfreq_valid` in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle.
- Reset values: `dr_pfreq_valid`=0, `pfreq_drop_cnt`=0, head=tail=count=0. `l2todr_pfreq_retry`=1 during the reset cycle, 0 on the first cycle after.
- Reset mid-operation: all queued entries are discarded with no output, and the drop counter clears.
- `dr_pfreq_valid` and `dr_pfreq` depend only on flops. `l2todr_pfreq_retry` depends only on `reset`. There is no input-to-output combinational path.

## Configuration
- `L2TODR_PFQ_DEDUP_EN` defined:
  - An incoming push whose `paddr` matches any valid entry is discarded. The queue is not modified and `pfreq_drop_cnt` does not count it.
  - The match includes the entry being popped in the same cycle.
  - An overflow push that matches is discarded, and no oldest-drop occurs.
  - Retry is still never asserted.
- Undefined: no address comparison. Duplicates are queued normally.

## Structure
- `I_l2todr_pfreq_type` and the paddr width constant remain in the shared `scmem.vh` package. No new typedefs are needed.
- `L2TODR_PFQ_DEDUP_EN` is defined alongside the other feature macros in `scmem.vh`.
- One sub-module, `l2todr_pfreq_match`, exists only under the dedup macro. It is a combinational DEPTH-way `paddr` compare masked by entry-valid bits, producing a hit bit.
- The queue itself is a single module.

## Test plan
- Push A (cycle 0), `dr_pfreq_retry`=0 → `dr_pfreq_valid`=1 with A in cycle 1, then empty in cycle 2; drop count 0.
- DEPTH=4, push A,B,C,D,E on consecutive cycles with `dr_pfreq_retry`=1 → count 4, `dr_pfreq`=B, `pfreq_drop_cnt`=1; release retry → pops in order B,C,D,E.
- Full queue, push F and pop in the same cycle → no drop, count stays 4, F is last out.
- Reset asserted with 3 entries queued → next cycle `dr_pfreq_valid`=0, count 0, `pfreq_drop_cnt`=0; `l2todr_pfreq_retry`=1 only during reset.
- `CNTW`=2, continuous overflow for 6 pushes → `pfreq_drop_cnt` reaches 3 and holds.
- With `L2TODR_PFQ_DEDUP_EN`: push paddr 0x1000 twice → one entry queued, drop count 0. Without the macro: two entries queued.

Source files
------------

// File: rtl/l2todr_pfreq_queue_pkg.sv
// ---------------------------------------------------------------------------
// l2todr_pfreq_queue_pkg
//
// Purpose: request type and address-width constants shared by the L2 to
// directory prefetch request queue. Stands in for the scmem.vh definitions
// of I_l2todr_pfreq_type so the slice builds on its own.
//
// Contents:
//   SC_PADDRBITS        line-address width carried in a prefetch request
//   SC_NODEIDBITS       requesting node id width
//   I_l2todr_pfreq_type packed request payload {nid, paddr}
//
// Feature macro used by consumers of this package: L2TODR_PFQ_DEDUP_EN
// (drop pushes whose paddr already sits in the queue).
// ---------------------------------------------------------------------------
package l2todr_pfreq_queue_pkg;

  localparam int SC_PADDRBITS  = 50;
  localparam int SC_NODEIDBITS = 5;

  typedef struct packed {
    logic [SC_NODEIDBITS-1:0] nid;
    logic [SC_PADDRBITS-1:0]  paddr;
  } I_l2todr_pfreq_type;

endpackage

// File: rtl/l2todr_pfreq_match.sv
// ---------------------------------------------------------------------------
// l2todr_pfreq_match
//
// Purpose: combinational DEPTH-way line-address compare used to suppress
// duplicate prefetch requests. Only built when L2TODR_PFQ_DEDUP_EN is
// defined.
//
// Ports:
//   entry_valid  in  DEPTH            occupancy mask of queue slots
//   entry_paddr  in  DEPTH x PADDR    line address held in each slot
//   req_paddr    in  PADDR            incoming request line address
//   hit          out 1                some occupied slot holds req_paddr
// ---------------------------------------------------------------------------
`ifdef L2TODR_PFQ_DEDUP_EN
module l2todr_pfreq_match
  import l2todr_pfreq_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]        entry_valid,
  input  logic [SC_PADDRBITS-1:0] entry_paddr [DEPTH],
  input  logic [SC_PADDRBITS-1:0] req_paddr,
  output logic                    hit
);

  logic [DEPTH-1:0] slot_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign slot_hit[gi] = entry_valid[gi] && (entry_paddr[gi] == req_paddr);
  end

  assign hit = |slot_hit;

endmodule
`endif

// File: rtl/l2todr_pfreq_queue.sv
// ---------------------------------------------------------------------------
// l2todr_pfreq_queue
//
// Purpose: circular prefetch-request buffer between the L2 prefetch port and
// the directory bank. Never stalls the L2; when full and not draining, the
// oldest entry is overwritten and a saturating drop counter increments.
//
// Parameters:
//   DEPTH  queue entries (4, 8 or 16)
//   CNTW   drop counter width
//
// Ports:
//   clk                 in   clock, posedge
//   reset               in   synchronous, active-high
//   l2todr_pfreq_valid  in   L2 request valid
//   l2todr_pfreq_retry  out  retry to L2 (only while reset)
//   l2todr_pfreq        in   request payload
//   dr_pfreq_valid      out  request valid toward directory
//   dr_pfreq_retry      in   retry from directory
//   dr_pfreq            out  oldest queued request
//   pfreq_drop_cnt      out  saturating overflow-drop count
//
// Build option: L2TODR_PFQ_DEDUP_EN discards pushes whose paddr matches any
// queued entry (including one popping this cycle); such discards are not
// counted as drops.
// ---------------------------------------------------------------------------
module l2todr_pfreq_queue
  import l2todr_pfreq_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2todr_pfreq_valid,
  output logic               l2todr_pfreq_retry,
  input  I_l2todr_pfreq_type l2todr_pfreq,
  output logic               dr_pfreq_valid,
  input  logic               dr_pfreq_retry,
  output I_l2todr_pfreq_type dr_pfreq,
  output logic [CNTW-1:0]    pfreq_drop_cnt
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PTRW-1:0]    head_q, head_d;
  logic [PTRW-1:0]    tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNTW-1:0]    drop_q, drop_d;
  I_l2todr_pfreq_type storage_q [DEPTH];

  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic overflow;

  // The L2 is held off only while the block is in reset.
  assign l2todr_pfreq_retry = reset;

  assign dr_pfreq_valid = (count_q != '0);
  assign dr_pfreq       = storage_q[head_q];
  assign pfreq_drop_cnt = drop_q;

  assign push_req = l2todr_pfreq_valid && !l2todr_pfreq_retry;
  assign pop      = dr_pfreq_valid && !dr_pfreq_retry;
  assign full     = (count_q == FULL_CNT);

`ifdef L2TODR_PFQ_DEDUP_EN
  logic [DEPTH-1:0]        entry_valid;
  logic [SC_PADDRBITS-1:0] entry_paddr [DEPTH];
  logic                    dup_hit;

  // A slot is occupied when its distance from head (mod DEPTH) is below
  // count. The popping entry is still counted, so it also suppresses pushes.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTRW-1:0] dist;
    assign dist            = PTRW'(gi) - head_q;
    assign entry_valid[gi] = ({1'b0, dist} < count_q);
    assign entry_paddr[gi] = storage_q[gi].paddr;
  end

  l2todr_pfreq_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entry_valid (entry_valid),
    .entry_paddr (entry_paddr),
    .req_paddr   (l2todr_pfreq.paddr),
    .hit         (dup_hit)
  );

  assign push = push_req && !dup_hit;
`else
  assign push = push_req;
`endif

  // Full with no drain: the new entry lands in the head slot and the head
  // moves on, discarding the oldest request.
  assign overflow = push && full && !pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;

    if (push) begin
      tail_d = tail_q + PTRW'(1);
    end
    if (pop || overflow) begin
      head_d = head_q + PTRW'(1);
    end

    if (push && !pop && !full) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (overflow && !(&drop_q)) begin
      drop_d = drop_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      storage_q[tail_q] <= l2todr_pfreq;
    end
  end

endmodule
